// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result path: writeback FSM states and default widths.
package matmul_pkg;

  localparam int NUM_LANES_DEF  = 4;
  localparam int BUS_WIDTH_DEF  = 256;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int BEAT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] grantIdx_o,
  output logic            anyGrant_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_o    = '0;
    grantIdx_o = '0;
    anyGrant_o = 1'b0;
    idx        = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr_i) + off) % N;
      if (req_i[idx]) begin
        grant_o      = '0;
        grant_o[idx] = 1'b1;
        grantIdx_o   = IDXW'(idx);
        anyGrant_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Drains the result shift lanes round-robin into the single result-memory write port.
module result_writeback_arbiter
  import matmul_pkg::*;
#(
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BEAT_WIDTH = BEAT_WIDTH_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_i,
  input  logic [ADDR_WIDTH-1:0]               base_addr_i,
  input  logic [ADDR_WIDTH-1:0]               lane_stride_i,
  input  logic [BEAT_WIDTH-1:0]               beats_per_lane_i,
  input  logic [NUM_LANES-1:0]                lane_valid_i,
  input  logic [NUM_LANES-1:0][BUS_WIDTH-1:0] lane_data_i,
  output logic [NUM_LANES-1:0]                lane_accepted_o,
  output logic                                wr_valid_o,
  output logic [ADDR_WIDTH-1:0]               wr_addr_o,
  output logic [BUS_WIDTH-1:0]                wr_data_o,
  input  logic                                wr_ready_i,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int IDXW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, stride_q;
  logic [BEAT_WIDTH-1:0] beats_q;
  logic [BEAT_WIDTH-1:0] cnt_q [NUM_LANES];
  logic [IDXW-1:0]       rrPtr_q, rrNext;
  logic                  wrValid_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [BUS_WIDTH-1:0]  wrData_q;

  logic [NUM_LANES-1:0]  laneReq, grant;
  logic [IDXW-1:0]       grantIdx;
  logic                  anyGrant, slotFree, allDrained, doGrant;

  // Lanes that already delivered their quota are masked even if they keep showing valid.
  always_comb begin
    laneReq    = '0;
    allDrained = 1'b1;
    for (int g = 0; g < NUM_LANES; g++) begin
      laneReq[g] = lane_valid_i[g] && (cnt_q[g] < beats_q) && (state_q == RUN);
      if (cnt_q[g] != beats_q) allDrained = 1'b0;
    end
  end

  rr_arbiter #(.N(NUM_LANES)) u_rr (
    .req_i      (laneReq),
    .ptr_i      (rrPtr_q),
    .grant_o    (grant),
    .grantIdx_o (grantIdx),
    .anyGrant_o (anyGrant)
  );

  assign slotFree        = !wrValid_q || wr_ready_i;
  assign doGrant         = (state_q == RUN) && slotFree && anyGrant && !reset;
  assign lane_accepted_o = doGrant ? grant : '0;
  assign rrNext          = (int'(grantIdx) == NUM_LANES - 1) ? '0 : grantIdx + IDXW'(1);
  assign wrAddr_d        = base_q + ADDR_WIDTH'(grantIdx) * stride_q + ADDR_WIDTH'(cnt_q[grantIdx]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (allDrained && slotFree) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A stalled write holds the output register; a ready with no new grant empties it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      beats_q   <= '0;
      rrPtr_q   <= '0;
      wrValid_q <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      for (int g = 0; g < NUM_LANES; g++) cnt_q[g] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        base_q   <= base_addr_i;
        stride_q <= lane_stride_i;
        beats_q  <= beats_per_lane_i;
        for (int g = 0; g < NUM_LANES; g++) cnt_q[g] <= '0;
      end
      if (doGrant) begin
        wrValid_q       <= 1'b1;
        wrAddr_q        <= wrAddr_d;
        wrData_q        <= lane_data_i[grantIdx];
        cnt_q[grantIdx] <= cnt_q[grantIdx] + BEAT_WIDTH'(1);
        rrPtr_q         <= rrNext;
      end else if (wr_ready_i) begin
        wrValid_q <= 1'b0;
      end
    end
  end

  assign wr_valid_o = wrValid_q;
  assign wr_addr_o  = wrAddr_q;
  assign wr_data_o  = wrData_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_result_writeback_arbiter.sv
// Directed bench: expected writes queued per test, a negedge monitor pops and compares them.
module tb_result_writeback_arbiter;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } expWrite_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [31:0]           baseAddr, laneStride;
  logic [15:0]           beats;
  logic [3:0]            laneValid;
  logic [3:0][255:0]     laneData;
  logic [3:0]            laneAccepted;
  logic                  wrValid, wrReady, busy, done;
  logic [31:0]           wrAddr;
  logic [255:0]          wrData;

  expWrite_t expQ[$];
  int        popCount[4];
  int        nCompared   = 0;
  int        nMismatched = 0;
  int        writeCount  = 0;
  int        doneCount   = 0;
  int        accCount    = 0;
  logic [3:0] accSeen;

  result_writeback_arbiter #(
    .NUM_LANES(4), .BUS_WIDTH(256), .ADDR_WIDTH(32), .BEAT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start),
    .base_addr_i(baseAddr), .lane_stride_i(laneStride), .beats_per_lane_i(beats),
    .lane_valid_i(laneValid), .lane_data_i(laneData), .lane_accepted_o(laneAccepted),
    .wr_valid_o(wrValid), .wr_addr_o(wrAddr), .wr_data_o(wrData), .wr_ready_i(wrReady),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] laneWord(input int lane, input int k);
    return {8'(lane + 1), 8'hEE, 16'(k), {7{32'hDEADBEEF}}};
  endfunction

  always_comb begin
    for (int g = 0; g < 4; g++) laneData[g] = laneWord(g, popCount[g]);
  end

  task automatic checkOutput(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Lane source: a head word advances one cycle after the arbiter pops it.
  initial forever begin
    @(negedge clk);
    accSeen = laneAccepted;
    @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) if (accSeen[g]) popCount[g]++;
  end

  initial forever begin
    expWrite_t e;
    @(negedge clk);
    if (laneAccepted != '0) begin
      accCount++;
      checkOutput("acceptOneHot", 256'($countones(laneAccepted)), 256'(1));
    end
    if (done) doneCount++;
    if (wrValid && wrReady) begin
      writeCount++;
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpectedWrite: got addr %0h expected no write", wrAddr);
      end else begin
        e = expQ.pop_front();
        checkOutput("wrAddr", 256'(wrAddr), 256'(e.addr));
        checkOutput("wrData", wrData, e.data);
      end
    end
  end

  task automatic expectOrder(input logic [31:0] b, input logic [31:0] s, input int order[$]);
    int        k[4];
    expWrite_t e;
    for (int g = 0; g < 4; g++) k[g] = 0;
    for (int i = 0; i < order.size(); i++) begin
      e.addr = b + 32'(order[i]) * s + 32'(k[order[i]]);
      e.data = laneWord(order[i], k[order[i]]);
      expQ.push_back(e);
      k[order[i]]++;
    end
  endtask

  task automatic clearPops();
    for (int g = 0; g < 4; g++) popCount[g] = 0;
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    clearPops();
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    baseAddr   = b;
    laneStride = s;
    beats      = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitWrites(input int target, input int budget, input string nm);
    int n = 0;
    while (writeCount < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(nm, 256'(writeCount), 256'(target));
  endtask

  task automatic waitDone(input int d0, input int budget, input string nm);
    int n = 0;
    while (doneCount == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(nm, 256'(doneCount - d0), 256'(1));
  endtask

  initial begin
    int ord[$];
    int d0, w0, a0;
    reset = 1'b1; start = 1'b0; baseAddr = '0; laneStride = '0; beats = '0;
    laneValid = '0; wrReady = 1'b1;
    clearPops();
    resetDut();

    @(negedge clk);
    checkOutput("rstWrValid", 256'(wrValid), 256'(0));
    checkOutput("rstWrAddr", 256'(wrAddr), 256'(0));
    checkOutput("rstBusy", 256'(busy), 256'(0));
    checkOutput("rstDone", 256'(done), 256'(0));
    checkOutput("rstAccepted", 256'(laneAccepted), 256'(0));

    $display("[TB] all lanes valid, two beats each");
    laneValid = 4'hF;
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    expectOrder(32'h100, 32'h10, ord);
    d0 = doneCount; w0 = writeCount;
    applyStimulus(32'h100, 32'h10, 16'd2);
    waitDone(d0, 40, "allLanesDone");
    repeat (3) @(negedge clk);
    checkOutput("allLanesWrites", 256'(writeCount - w0), 256'(8));
    checkOutput("allLanesDoneOnce", 256'(doneCount - d0), 256'(1));
    checkOutput("allLanesQueue", 256'(expQ.size()), 256'(0));

    $display("[TB] only lane 2 valid, three beats");
    resetDut();
    laneValid = 4'b0100;
    ord = '{2, 2, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1};
    expectOrder(32'h200, 32'h40, ord);
    d0 = doneCount; w0 = writeCount;
    applyStimulus(32'h200, 32'h40, 16'd3);
    waitWrites(w0 + 3, 30, "lane2Writes");
    repeat (6) @(negedge clk);
    checkOutput("lane2StillBusy", 256'(busy), 256'(1));
    checkOutput("lane2NoDone", 256'(doneCount - d0), 256'(0));
    checkOutput("lane2Pops", 256'(popCount[2]), 256'(3));
    checkOutput("lane0Pops", 256'(popCount[0]), 256'(0));
    checkOutput("lane3Pops", 256'(popCount[3]), 256'(0));
    @(posedge clk); #1;
    laneValid = 4'hF;
    waitDone(d0, 40, "lane2Done");
    checkOutput("lane2Queue", 256'(expQ.size()), 256'(0));

    $display("[TB] write port stalled for five cycles");
    resetDut();
    laneValid = 4'hF;
    wrReady = 1'b0;
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    expectOrder(32'h300, 32'h20, ord);
    d0 = doneCount;
    applyStimulus(32'h300, 32'h20, 16'd2);
    begin
      int n = 0;
      while (!wrValid && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      checkOutput("stallValid", 256'(wrValid), 256'(1));
      checkOutput("stallAddr", 256'(wrAddr), 256'(32'h300));
      checkOutput("stallData", wrData, laneWord(0, 0));
      checkOutput("stallAccepted", 256'(laneAccepted), 256'(0));
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    wrReady = 1'b1;
    w0 = writeCount;
    repeat (8) @(negedge clk);
    checkOutput("stallThroughput", 256'(writeCount - w0), 256'(8));
    waitDone(d0, 10, "stallDone");

    $display("[TB] zero beats per lane");
    resetDut();
    d0 = doneCount; w0 = writeCount; a0 = accCount;
    applyStimulus(32'h700, 32'h10, 16'd0);
    @(negedge clk);
    checkOutput("zeroBusyRun", 256'(busy), 256'(1));
    checkOutput("zeroDoneEarly", 256'(done), 256'(0));
    @(negedge clk);
    checkOutput("zeroDonePulse", 256'(done), 256'(1));
    repeat (4) @(negedge clk);
    checkOutput("zeroWrites", 256'(writeCount - w0), 256'(0));
    checkOutput("zeroPops", 256'(accCount - a0), 256'(0));
    checkOutput("zeroDoneOnce", 256'(doneCount - d0), 256'(1));

    $display("[TB] reset after three of eight beats");
    resetDut();
    laneValid = 4'hF;
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    expectOrder(32'h100, 32'h10, ord);
    d0 = doneCount; w0 = writeCount;
    applyStimulus(32'h100, 32'h10, 16'd2);
    begin
      int n = 0;
      while (writeCount - w0 < 3 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortWrites", 256'(writeCount - w0), 256'(3));
    checkOutput("abortWrValid", 256'(wrValid), 256'(0));
    checkOutput("abortWrAddr", 256'(wrAddr), 256'(0));
    checkOutput("abortWrData", wrData, 256'(0));
    checkOutput("abortBusy", 256'(busy), 256'(0));
    checkOutput("abortAccepted", 256'(laneAccepted), 256'(0));
    #2;
    clearPops();
    expQ.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abortNoDone", 256'(doneCount - d0), 256'(0));
    ord = '{0, 1, 2, 3};
    expectOrder(32'h400, 32'h8, ord);
    d0 = doneCount;
    applyStimulus(32'h400, 32'h8, 16'd1);
    waitDone(d0, 30, "restartDone");
    checkOutput("restartQueue", 256'(expQ.size()), 256'(0));

    $display("[TB] start pulsed while busy");
    resetDut();
    laneValid = 4'hF;
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    expectOrder(32'h500, 32'h20, ord);
    d0 = doneCount;
    applyStimulus(32'h500, 32'h20, 16'd2);
    @(posedge clk); #1;
    baseAddr = 32'hFFF0; laneStride = 32'h1; beats = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(d0, 40, "busyStartDone");
    repeat (6) @(negedge clk);
    checkOutput("busyStartDoneOnce", 256'(doneCount - d0), 256'(1));
    checkOutput("busyStartIdle", 256'(busy), 256'(0));
    checkOutput("busyStartQueue", 256'(expQ.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
